// File: rtl/jt89_regs_if.sv
//------------------------------------------------------------------------------
// Module      : jt89_regs_if
// Description : Host write bus of the JT89 PSG register file. The host drives
//               the data byte, chip select and write strobe, and the register
//               file returns ready.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface jt89_regs_if;
  logic [7:0] din;
  logic       cs_n;
  logic       wr_n;
  logic       ready;

  modport master (output din, output cs_n, output wr_n, input ready);
  modport slave  (input din, input cs_n, input wr_n, output ready);
endinterface

`default_nettype wire

// File: rtl/jt89_regs.sv
//------------------------------------------------------------------------------
// Module      : jt89_regs
// Description : JT89 PSG host write decoder and register file. It decodes
//               SN76489-style latch/data bytes into tone periods, attenuations
//               and the noise control field. It also generates the noise clear
//               pulse and the divided channel clock enable.
//               Optional macro JT89_READY_EN adds a busy window after each
//               accepted write, during which further writes are ignored.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module jt89_regs #(
  parameter int CLKDIV    = 16,
  parameter int READY_CYC = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  jt89_regs_if.slave  bus,
  output logic        clken,
  output logic [9:0]  tone0,
  output logic [9:0]  tone1,
  output logic [9:0]  tone2,
  output logic [3:0]  vol0,
  output logic [3:0]  vol1,
  output logic [3:0]  vol2,
  output logic [3:0]  vol3,
  output logic [2:0]  ctrl3,
  output logic        noise_clr
);

  localparam int                 c_CNT_W    = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKDIV - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               r_clken;
  logic               r_wr_n_d;
  logic [2:0]         r_sel;      // {channel, type}; type 1 = volume
  logic [9:0]         r_tone0;
  logic [9:0]         r_tone1;
  logic [9:0]         r_tone2;
  logic [3:0]         r_vol0;
  logic [3:0]         r_vol1;
  logic [3:0]         r_vol2;
  logic [3:0]         r_vol3;
  logic [2:0]         r_ctrl3;
  logic               r_noise_clr;

  logic               w_ready;
  logic               w_accept;
  logic               w_latch;
  logic [2:0]         w_sel;

  // A latch byte selects its own target; a data byte goes to the stored select
  assign w_latch  = bus.din[7];
  assign w_sel    = w_latch ? bus.din[6:4] : r_sel;
  assign w_accept = ~bus.cs_n & ~bus.wr_n & r_wr_n_d & w_ready;

`ifdef JT89_READY_EN
  localparam int                  c_BUSY_W    = (READY_CYC > 2) ? $clog2(READY_CYC) : 1;
  localparam logic [c_BUSY_W-1:0] c_BUSY_LOAD = c_BUSY_W'(READY_CYC - 1);

  logic [c_BUSY_W-1:0] r_busy;
  logic                r_ready;

  // Busy window: ready drops for READY_CYC cycles after each accepted write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b1;
      r_busy  <= '0;
    end else if (w_accept) begin
      r_ready <= 1'b0;
      r_busy  <= c_BUSY_LOAD;
    end else if (!r_ready) begin
      if (r_busy == '0) r_ready <= 1'b1;
      else              r_busy  <= r_busy - 1'b1;
    end
  end

  assign w_ready = r_ready;
`else
  // No busy window in this build: READY_CYC has no effect and ready stays high
  assign w_ready = (READY_CYC != 0) | 1'b1;
`endif

  assign bus.ready = w_ready;

  // Free-running divider; the enable is registered so it starts low after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_clken <= 1'b0;
    end else begin
      r_cnt   <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + 1'b1;
      r_clken <= (r_cnt == c_CNT_LAST);
    end
  end

  // Strobe history so a held-low wr_n produces a single write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wr_n_d <= 1'b1;
    else        r_wr_n_d <= bus.wr_n;
  end

  // Byte decode into the register file, with a one-cycle noise clear pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel       <= 3'b000;
      r_tone0     <= '0;
      r_tone1     <= '0;
      r_tone2     <= '0;
      r_vol0      <= 4'hF;
      r_vol1      <= 4'hF;
      r_vol2      <= 4'hF;
      r_vol3      <= 4'hF;
      r_ctrl3     <= '0;
      r_noise_clr <= 1'b0;
    end else begin
      r_noise_clr <= 1'b0;
      if (w_accept) begin
        if (w_latch) r_sel <= bus.din[6:4];
        if (w_sel[0]) begin
          case (w_sel[2:1])
            2'd0:    r_vol0 <= bus.din[3:0];
            2'd1:    r_vol1 <= bus.din[3:0];
            2'd2:    r_vol2 <= bus.din[3:0];
            default: r_vol3 <= bus.din[3:0];
          endcase
        end else begin
          // Latch bytes carry the low period nibble, data bytes the upper six bits
          case (w_sel[2:1])
            2'd0: begin
              if (w_latch) r_tone0[3:0] <= bus.din[3:0];
              else         r_tone0[9:4] <= bus.din[5:0];
            end
            2'd1: begin
              if (w_latch) r_tone1[3:0] <= bus.din[3:0];
              else         r_tone1[9:4] <= bus.din[5:0];
            end
            2'd2: begin
              if (w_latch) r_tone2[3:0] <= bus.din[3:0];
              else         r_tone2[9:4] <= bus.din[5:0];
            end
            default: begin
              r_ctrl3     <= bus.din[2:0];
              r_noise_clr <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign clken     = r_clken;
  assign tone0     = r_tone0;
  assign tone1     = r_tone1;
  assign tone2     = r_tone2;
  assign vol0      = r_vol0;
  assign vol1      = r_vol1;
  assign vol2      = r_vol2;
  assign vol3      = r_vol3;
  assign ctrl3     = r_ctrl3;
  assign noise_clr = r_noise_clr;

endmodule

`default_nettype wire

// File: tb/tb_jt89_regs.sv
//------------------------------------------------------------------------------
// Module      : tb_jt89_regs
// Description : Self-checking bench for jt89_regs: vector table of host writes
//               with expected register state, plus reset, clock-enable, busy
//               window and reset-during-write sequences.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_jt89_regs;

  logic       clk;
  logic       rst_n;
  logic       clken;
  logic [9:0] tone0, tone1, tone2;
  logic [3:0] vol0, vol1, vol2, vol3;
  logic [2:0] ctrl3;
  logic       noise_clr;

  int n_vec = 0;
  int n_bad = 0;

  jt89_regs_if bus ();

  jt89_regs #(.CLKDIV(16), .READY_CYC(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .clken     (clken),
    .tone0     (tone0),
    .tone1     (tone1),
    .tone2     (tone2),
    .vol0      (vol0),
    .vol1      (vol1),
    .vol2      (vol2),
    .vol3      (vol3),
    .ctrl3     (ctrl3),
    .noise_clr (noise_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] din;
    logic       cs_n;
    logic [7:0] hold;
    logic [9:0] t0;
    logic [9:0] t1;
    logic [9:0] t2;
    logic [3:0] v0;
    logic [3:0] v1;
    logic [3:0] v2;
    logic [3:0] v3;
    logic [2:0] c3;
    logic [1:0] clr;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] state_word();
    return {15'd0, tone0, tone1, tone2, vol0, vol1, vol2, vol3, ctrl3};
  endfunction

  // Wait for ready, drive one write held for 'hold' cycles, count noise_clr pulses
  task automatic do_write(input logic [7:0] d, input logic c, input int hold, output int pulses);
    int w;
    pulses = 0;
    w = 0;
    while (!bus.ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (!bus.ready) chk("ready_timeout", 64'(bus.ready), 64'd1);
    @(negedge clk);
    bus.din = d; bus.cs_n = c; bus.wr_n = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (noise_clr) pulses++;
    end
    @(negedge clk);
    bus.wr_n = 1'b1; bus.cs_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (noise_clr) pulses++;
    end
  endtask

  initial begin
    int pulses;
    int gap;
    int low_cnt;

    // din, cs_n, hold, tone0, tone1, tone2, vol0..3, ctrl3, noise_clr pulses
    vecs[0]  = '{8'h8E, 1'b0, 8'd1,  10'h00E, 10'h000, 10'h000, 4'hF, 4'hF, 4'hF, 4'hF, 3'd0, 2'd0};
    vecs[1]  = '{8'h2A, 1'b0, 8'd1,  10'h2AE, 10'h000, 10'h000, 4'hF, 4'hF, 4'hF, 4'hF, 3'd0, 2'd0};
    vecs[2]  = '{8'h55, 1'b0, 8'd1,  10'h15E, 10'h000, 10'h000, 4'hF, 4'hF, 4'hF, 4'hF, 3'd0, 2'd0};
    vecs[3]  = '{8'hE5, 1'b0, 8'd1,  10'h15E, 10'h000, 10'h000, 4'hF, 4'hF, 4'hF, 4'hF, 3'd5, 2'd1};
    vecs[4]  = '{8'h06, 1'b0, 8'd1,  10'h15E, 10'h000, 10'h000, 4'hF, 4'hF, 4'hF, 4'hF, 3'd6, 2'd1};
    vecs[5]  = '{8'hD3, 1'b0, 8'd1,  10'h15E, 10'h000, 10'h000, 4'hF, 4'hF, 4'h3, 4'hF, 3'd6, 2'd0};
    vecs[6]  = '{8'h07, 1'b0, 8'd1,  10'h15E, 10'h000, 10'h000, 4'hF, 4'hF, 4'h7, 4'hF, 3'd6, 2'd0};
    vecs[7]  = '{8'h4C, 1'b0, 8'd1,  10'h15E, 10'h000, 10'h000, 4'hF, 4'hF, 4'hC, 4'hF, 3'd6, 2'd0};
    vecs[8]  = '{8'hA9, 1'b0, 8'd1,  10'h15E, 10'h009, 10'h000, 4'hF, 4'hF, 4'hC, 4'hF, 3'd6, 2'd0};
    vecs[9]  = '{8'h3F, 1'b0, 8'd1,  10'h15E, 10'h3F9, 10'h000, 4'hF, 4'hF, 4'hC, 4'hF, 3'd6, 2'd0};
    vecs[10] = '{8'hC4, 1'b0, 8'd1,  10'h15E, 10'h3F9, 10'h004, 4'hF, 4'hF, 4'hC, 4'hF, 3'd6, 2'd0};
    vecs[11] = '{8'h90, 1'b0, 8'd1,  10'h15E, 10'h3F9, 10'h004, 4'h0, 4'hF, 4'hC, 4'hF, 3'd6, 2'd0};
    vecs[12] = '{8'h9F, 1'b0, 8'd10, 10'h15E, 10'h3F9, 10'h004, 4'hF, 4'hF, 4'hC, 4'hF, 3'd6, 2'd0};
    vecs[13] = '{8'hE3, 1'b0, 8'd10, 10'h15E, 10'h3F9, 10'h004, 4'hF, 4'hF, 4'hC, 4'hF, 3'd3, 2'd1};
    vecs[14] = '{8'h80, 1'b1, 8'd1,  10'h15E, 10'h3F9, 10'h004, 4'hF, 4'hF, 4'hC, 4'hF, 3'd3, 2'd0};
    vecs[15] = '{8'h01, 1'b0, 8'd1,  10'h15E, 10'h3F9, 10'h004, 4'hF, 4'hF, 4'hC, 4'hF, 3'd1, 2'd1};
    vecs[16] = '{8'hB7, 1'b0, 8'd1,  10'h15E, 10'h3F9, 10'h004, 4'hF, 4'h7, 4'hC, 4'hF, 3'd1, 2'd0};
    vecs[17] = '{8'hFA, 1'b0, 8'd1,  10'h15E, 10'h3F9, 10'h004, 4'hF, 4'h7, 4'hC, 4'hA, 3'd1, 2'd0};
    vecs[18] = '{8'h0B, 1'b0, 8'd1,  10'h15E, 10'h3F9, 10'h004, 4'hF, 4'h7, 4'hC, 4'hB, 3'd1, 2'd0};
    vecs[19] = '{8'h7E, 1'b0, 8'd1,  10'h15E, 10'h3F9, 10'h004, 4'hF, 4'h7, 4'hC, 4'hE, 3'd1, 2'd0};

    bus.din = 8'h00; bus.cs_n = 1'b1; bus.wr_n = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_regs", state_word(), {15'd0, 10'h0, 10'h0, 10'h0, 4'hF, 4'hF, 4'hF, 4'hF, 3'd0});
    chk("reset_flags", {61'd0, bus.ready, clken, noise_clr}, 64'b100);

    // First clken 16 edges after release, then every 16
    @(negedge clk);
    rst_n = 1'b1;
    gap = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      gap++;
      if (clken) break;
    end
    chk("clken_first", 64'(gap), 64'd16);
    for (int p = 0; p < 2; p++) begin
      gap = 0;
      for (int i = 0; i < 64; i++) begin
        @(posedge clk); #1;
        gap++;
        if (clken) break;
      end
      chk("clken_period", 64'(gap), 64'd16);
    end

    for (int k = 0; k < 20; k++) begin
      do_write(vecs[k].din, vecs[k].cs_n, int'(vecs[k].hold), pulses);
      chk($sformatf("vec%0d_regs", k), state_word(),
          {15'd0, vecs[k].t0, vecs[k].t1, vecs[k].t2,
           vecs[k].v0, vecs[k].v1, vecs[k].v2, vecs[k].v3, vecs[k].c3});
      chk($sformatf("vec%0d_noise_clr", k), 64'(pulses), 64'(vecs[k].clr));
    end

`ifndef JT89_READY_EN
    // Ready never drops in this build
    @(negedge clk);
    bus.din = 8'hB0; bus.cs_n = 1'b0; bus.wr_n = 1'b0;
    @(posedge clk); #1;
    chk("ready_const", {60'd0, vol1, 3'd0, bus.ready}, {60'd0, 4'h0, 3'd0, 1'b1});
    @(negedge clk);
    bus.wr_n = 1'b1; bus.cs_n = 1'b1;
`else
    // Busy window: 32 low cycles, a write inside it is dropped
    @(negedge clk);
    bus.din = 8'h81; bus.cs_n = 1'b0; bus.wr_n = 1'b0;
    low_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      if (bus.ready) break;
      low_cnt++;
      @(negedge clk);
      if (i == 9) begin
        bus.din = 8'h85; bus.cs_n = 1'b0; bus.wr_n = 1'b0;
      end else begin
        bus.wr_n = 1'b1; bus.cs_n = 1'b1;
      end
    end
    chk("ready_low_cycles", 64'(low_cnt), 64'd32);
    chk("busy_write_ignored", 64'(tone0), 64'h151);
    do_write(8'h85, 1'b0, 1, pulses);
    chk("write_after_ready", 64'(tone0), 64'h155);
`endif

    // Asynchronous reset asserted during a write discards it
    @(negedge clk);
    bus.din = 8'h8F; bus.cs_n = 1'b0; bus.wr_n = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset", state_word(), {15'd0, 10'h0, 10'h0, 10'h0, 4'hF, 4'hF, 4'hF, 4'hF, 3'd0});
    @(posedge clk); #1;
    chk("reset_mid_write", {state_word()[62:0], noise_clr},
        {15'd0, 10'h0, 10'h0, 10'h0, 4'hF, 4'hF, 4'hF, 4'hF, 3'd0, 1'b0});
    @(negedge clk);
    bus.wr_n = 1'b1; bus.cs_n = 1'b1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("after_reset_release", 64'(tone0), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jt89_regs.md
Name: jt89_regs

Overview:
Host write interface and register file of the JT89 PSG; sits directly upstream of the tone and noise channel generators.
- Decodes SN76489-style latch/data byte writes into per-channel tone periods, attenuations and the noise control field.
- Generates the noise-register clear pulse and the divided channel clock enable that the noise and tone stages consume.

Parameters:
CLKDIV, 16, clk cycles per clken pulse (range 2..1024)
READY_CYC, 32, clk cycles ready stays low after an accepted write (used only with JT89_READY_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
din  input  8  host write data
cs_n  input  1  chip select, active low
wr_n  input  1  write strobe, active low, synchronous to clk
ready  output  1  high when a new write will be accepted
clken  output  1  one-cycle pulse every CLKDIV clk cycles, drives channel stages
tone0  output  10  channel 0 period
tone1  output  10  channel 1 period
tone2  output  10  channel 2 period
vol0  output  4  channel 0 attenuation (15 = silent)
vol1  output  4  channel 1 attenuation
vol2  output  4  channel 2 attenuation
vol3  output  4  noise attenuation
ctrl3  output  3  noise control: [2] white/periodic, [1:0] rate select (3 = use channel 2)
noise_clr  output  1  one-cycle pulse: reload noise shift register

Behaviour:
Reset:
- rst_n low asynchronously forces tone0..2=0, vol0..3=4'hF, ctrl3=0, noise_clr=0, clken=0, ready=1.
- Latched register select = channel 0 tone; divider count = 0; busy counter = 0; wr_n history = 1.
Write acceptance:
- wr_n is registered each clk.
- A write is accepted on the cycle where cs_n=0, wr_n=0, previous wr_n=1 and ready=1.
- Holding wr_n low yields exactly one write. A cs_n=1 cycle never accepts.
Byte decode (outputs update on the clk edge after acceptance, i.e. 1-cycle latency):
- din[7]=1 is a latch byte. Store select = {din[6:5] channel, din[4] type}.
  - type 1: vol[ch] <= din[3:0].
  - type 0, ch 0..2: tone[ch][3:0] <= din[3:0]; tone[9:4] unchanged.
  - type 0, ch 3: ctrl3 <= din[2:0] and noise_clr pulses.
- din[7]=0 is a data byte, applied to the stored select; the select is unchanged.
  - tone: tone[ch][9:4] <= din[5:0].
  - volume: vol[ch] <= din[3:0].
  - noise: ctrl3 <= din[2:0] and noise_clr pulses.
  - din[6] is ignored for every data byte.
noise_clr:
- High exactly one clk cycle, coincident with the ctrl3 update.
- Never high on tone or volume writes.
clken:
- Free-running counter 0..CLKDIV-1, clken=1 when count==CLKDIV-1, wraps to 0.
- Unaffected by writes.
- First pulse occurs at cycle CLKDIV after reset release.
Simultaneous events:
- A write coinciding with clken is applied normally; clken is not delayed.
- Reset asserted mid-write discards the write.

Optional Feature:
JT89_READY_EN
- Defined: an accepted write drops ready on the next clk and holds it low for READY_CYC cycles, then ready returns to 1. A busy counter loads READY_CYC-1 and counts down to 0. Write attempts while ready=0 are ignored completely (no register change, no noise_clr, select unchanged). A write is accepted again on the first cycle ready=1, provided a new wr_n falling edge occurs.
- Undefined: ready is constant 1, the busy counter is not built, and every valid strobe edge is accepted.

Test Plan:
- Reset release -> vol0..3=4'hF, tone0..2=0, ctrl3=0, ready=1; first clken at cycle 16, then every 16 cycles.
- Write 8'h8E then 8'h2A -> tone0=10'h2AE; the second byte leaves the latch select at channel 0 tone.
- Write 8'hE5 -> ctrl3=3'b101 and noise_clr high for exactly one cycle. Then write 8'h06 -> ctrl3=3'b110 and a second single-cycle noise_clr.
- Write 8'hD3 then 8'h07 -> vol2=3 then vol2=7; tone2 and noise_clr unchanged.
- Hold cs_n=0, wr_n=0 for 10 cycles with din=8'h9F -> vol0=15 applied once. A write with cs_n=1 -> no change.
- With JT89_READY_EN:
  - Write 8'h81 -> ready low for 32 cycles.
  - Write 8'h85 at cycle 10 -> ignored, tone0[3:0] stays 1.
  - The same write after ready returns -> tone0[3:0]=5.
